mem_req_ctrl: RTL and testbench

Request-side controller that sits directly upstream of the lab memory (`mem`). It accepts read/write commands from the test or traffic source over a valid/ready handshake and buffers them in a small FIFO. It drives the memory's address, data, read and write pins one operation per cycle and returns read data in order over a second valid/ready channel. Response credits are tracked so read data is never dropped when the consumer stalls.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_req_fifo.sv | 49 ++++
 rtl/mem_req_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side types: default widths and the request bundle.
// Used by mem_req_ctrl, mem_interf and mem_test.
package mem_pkg;

    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 8;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit
// so full and empty are told apart without a counter.
module mem_req_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wptr_q, wptr_d;
    logic [PW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW] != rptr_q[PW]) &&
                     (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign rdata_o = mem_q[rptr_q[PW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request-side memory controller: FIFO, single-op issue, in-order read return.
// Define MEM_REQ_CTRL_STATS_EN to add saturating write/read issue counters.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef MEM_REQ_CTRL_STATS_EN
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt,
`endif
    input  logic              rsp_ready
);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam int RW  = $bits(req_t);
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int RPW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    req_t          push_req;
    req_t          head;
    logic [RW-1:0] head_raw;
    logic          fifo_full, fifo_empty;
    logic          push, issue, rd_ok;

    logic [0:0]        state_q, state_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_p1_q;

    logic [DATA_W-1:0] rsp_buf_q [RSP_DEPTH];
    logic [RPW-1:0]    rsp_wp_q, rsp_wp_d;
    logic [RPW-1:0]    rsp_rp_q, rsp_rp_d;
    logic [CW-1:0]     rsp_cnt_q, rsp_cnt_d;
    logic [CW:0]       used;
    logic              rsp_push, rsp_pop;

    assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign head      = req_t'(head_raw);
    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;

    mem_req_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_req),
        .pop_i   (issue),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign mem_read    = (state_q == ST_ISSUE) && !wr_q;
    assign mem_write   = (state_q == ST_ISSUE) && wr_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;

    // A read needs a guaranteed slot: on pins, in the memory, or buffered.
    assign used  = (CW+1)'(rsp_cnt_q) + (CW+1)'(rd_p1_q) + (CW+1)'(mem_read);
    assign rd_ok = used < (CW+1)'(RSP_DEPTH);
    assign issue = !fifo_empty && (head.write || rd_ok);

    assign state_d = issue ? ST_ISSUE : ST_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_p1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_p1_q <= mem_read;
            if (issue) begin
                wr_q    <= head.write;
                addr_q  <= head.addr;
                wdata_q <= head.wdata;
            end
        end
    end

    assign rsp_push  = rd_p1_q;
    assign rsp_valid = (rsp_cnt_q != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_buf_q[rsp_rp_q];

    always_comb begin
        rsp_wp_d  = rsp_wp_q;
        rsp_rp_d  = rsp_rp_q;
        rsp_cnt_d = rsp_cnt_q + CW'(rsp_push) - CW'(rsp_pop);
        if (rsp_push)
            rsp_wp_d = (rsp_wp_q == RPW'(RSP_DEPTH - 1)) ? '0 : rsp_wp_q + 1'b1;
        if (rsp_pop)
            rsp_rp_d = (rsp_rp_q == RPW'(RSP_DEPTH - 1)) ? '0 : rsp_rp_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_wp_q  <= '0;
            rsp_rp_q  <= '0;
            rsp_cnt_q <= '0;
        end else begin
            rsp_wp_q  <= rsp_wp_d;
            rsp_rp_q  <= rsp_rp_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) rsp_buf_q[rsp_wp_q] <= mem_data_out;
    end

`ifdef MEM_REQ_CTRL_STATS_EN
    logic [15:0] stat_wr_q, stat_rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else if (issue) begin
            if (head.write && stat_wr_q != 16'hFFFF)
                stat_wr_q <= stat_wr_q + 16'd1;
            if (!head.write && stat_rd_q != 16'hFFFF)
                stat_rd_q <= stat_rd_q + 16'd1;
        end
    end

    assign stat_wr_cnt = stat_wr_q;
    assign stat_rd_cnt = stat_rd_q;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural memory model.
// Stats checks are built only when MEM_REQ_CTRL_STATS_EN is defined.
`timescale 1ns/1ps
module tb_mem_req_ctrl;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_data_out;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
`ifdef MEM_REQ_CTRL_STATS_EN
    logic [15:0]   stat_wr_cnt;
    logic [15:0]   stat_rd_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int accepts = 0;
    logic both_hi = 1'b0;
    logic [DW-1:0] rq[$];
    logic [DW-1:0] mem_arr [32];

    always #5 clk = ~clk;

    mem_req_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
`ifdef MEM_REQ_CTRL_STATS_EN
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_rd_cnt  (stat_rd_cnt),
`endif
        .rsp_ready    (rsp_ready)
    );

    // Lab memory: registered read data, synchronous write.
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr] <= mem_data_in;
        if (mem_read)  mem_data_out <= mem_arr[mem_addr];
    end

    always @(posedge clk) begin
        if (rsp_valid && rsp_ready) rq.push_back(rsp_rdata);
        if (mem_read) rd_pulses <= rd_pulses + 1;
        if (mem_read && mem_write) both_hi <= 1'b1;
        if (req_valid && req_ready) accepts <= accepts + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("send_timeout", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    logic [DW-1:0] exp6 [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
    int p0, a0, n;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);

        // Write 0xA5 to 3 then read it back, tracking latency.
        send(1'b1, 5'd3, 8'hA5);
        send(1'b0, 5'd3, 8'h00);
        @(negedge clk);
        chk("wr_pulse", mem_write, 1);
        chk("wr_addr", mem_addr, 3);
        chk("wr_data", mem_data_in, 8'hA5);
        chk("wr_no_read", mem_read, 0);
        @(negedge clk);
        chk("rd_pulse", mem_read, 1);
        chk("rd_wr_low", mem_write, 0);
        chk("rd_addr", mem_addr, 3);
        chk("lat_k2", rsp_valid, 0);
        @(negedge clk);
        chk("lat_k3", rsp_valid, 0);
        chk("rd_one_cycle", mem_read, 0);
        @(negedge clk);
        chk("lat_k4_valid", rsp_valid, 1);
        chk("lat_k4_data", rsp_rdata, 8'hA5);
        repeat (3) @(negedge clk);
        chk("rsp1_count", rq.size(), 1);
        rq.delete();

        // Back-to-back writes then reads.
        for (int i = 0; i < 4; i++) send(1'b1, AW'(i), DW'(8'h10 + i));
        for (int i = 0; i < 4; i++) send(1'b0, AW'(i), 8'h00);
        repeat (8) @(negedge clk);
        chk("b2b_count", rq.size(), 4);
        for (int i = 0; i < 4; i++) chk("b2b_data", rq[i], 8'h10 + i);
        rq.delete();

        // Backpressure: six reads with the consumer stalled.
        rsp_ready = 1'b0;
        p0 = rd_pulses;
        for (int i = 0; i < 6; i++) send(1'b0, AW'(i % 4), 8'h00);
        @(negedge clk);
        chk("bp_full", req_ready, 0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 5'd7;
        req_wdata = 8'h77;
        a0 = accepts;
        repeat (3) @(negedge clk);
        chk("bp_rd_pulses", rd_pulses - p0, 2);
        chk("bp_no_accept", accepts - a0, 0);
        chk("bp_no_rsp", rq.size(), 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_release", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("bp_count", rq.size(), 6);
        for (int i = 0; i < 6; i++) chk("bp_data", rq[i], exp6[i]);
        send(1'b0, 5'd7, 8'h00);
        repeat (6) @(negedge clk);
        chk("stalled_wr", rq[6], 8'h77);
        rq.delete();

        // Reset with reads in flight.
        send(1'b0, 5'd0, 8'h00);
        send(1'b0, 5'd1, 8'h00);
        @(negedge clk);
        chk("pre_rst_read", mem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_read", mem_read, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_stale_rsp", rq.size(), 0);
        chk("no_stale_valid", rsp_valid, 0);

`ifdef MEM_REQ_CTRL_STATS_EN
        chk("stat_wr_rst", stat_wr_cnt, 0);
        chk("stat_rd_rst", stat_rd_cnt, 0);
        for (int i = 0; i < 3; i++) send(1'b1, AW'(8 + i), DW'(i));
        for (int i = 0; i < 2; i++) send(1'b0, AW'(8 + i), 8'h00);
        repeat (6) @(negedge clk);
        chk("stat_wr3", stat_wr_cnt, 3);
        chk("stat_rd2", stat_rd_cnt, 2);
        for (int i = 0; i < 65535; i++) send(1'b1, 5'd8, 8'h00);
        repeat (4) @(negedge clk);
        chk("stat_wr_sat", stat_wr_cnt, 16'hFFFF);
        chk("stat_rd_hold", stat_rd_cnt, 2);
`endif

        chk("never_both", both_hi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
